// File: rtl/score_bcd_accum_pkg.sv
// Shared types and constants for the BCD score accumulator.
package score_bcd_accum_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned NDIGITS = 4;

  localparam logic [15:0] PTS1_DEF = 16'h0040;
  localparam logic [15:0] PTS2_DEF = 16'h0100;
  localparam logic [15:0] PTS3_DEF = 16'h0300;
  localparam logic [15:0] PTS4_DEF = 16'h1200;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    COMMIT
  } state_t;

endpackage

// File: rtl/score_bcd_accum_digit_add.sv
// Single-digit BCD adder with carry; shared across all digits of the score.
module bcd_digit_add
  import score_bcd_accum_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] sum,
  output logic               cout
);

  logic [DIGIT_W:0] raw;
  logic [DIGIT_W:0] adj;

  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
    adj  = raw - (DIGIT_W + 1)'(10);
    sum  = raw[DIGIT_W-1:0];
    cout = 1'b0;
    if (raw > (DIGIT_W + 1)'(9)) begin
      sum  = adj[DIGIT_W-1:0];
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/score_bcd_accum.sv
// 4-digit BCD score keeper: adds line-clear points digit-serially, commits
// the whole result at once and saturates at 9999.
module score_bcd_accum
  import score_bcd_accum_pkg::*;
#(
  parameter logic [15:0] PTS1 = PTS1_DEF,
  parameter logic [15:0] PTS2 = PTS2_DEF,
  parameter logic [15:0] PTS3 = PTS3_DEF,
  parameter logic [15:0] PTS4 = PTS4_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       line_valid,
  input  logic [2:0] line_cnt,
  output logic       line_ready,
  output logic [3:0] s4,
  output logic [3:0] s3,
  output logic [3:0] s2,
  output logic [3:0] s1,
  output logic       sat
);

  localparam int unsigned SCORE_W = DIGIT_W * NDIGITS;

  state_t               state, state_nxt;
  logic [1:0]           idx;
  logic [SCORE_W-1:0]   work;
  logic [SCORE_W-1:0]   addend;
  logic [SCORE_W-1:0]   score;
  logic [SCORE_W-1:0]   table_pts;
  logic                 carry;
  logic                 sat_r;
  logic                 accept;
  logic [DIGIT_W-1:0]   dig_a, dig_b, dig_sum;
  logic                 dig_cout;

  assign line_ready = (state == IDLE);
  assign accept     = line_valid & line_ready & ~clr;

  always_comb begin
    table_pts = '0;
    case (line_cnt)
      3'd1:    table_pts = PTS1;
      3'd2:    table_pts = PTS2;
      3'd3:    table_pts = PTS3;
      3'd4:    table_pts = PTS4;
      default: table_pts = '0;
    endcase
  end

  // One adder, steered to the current digit by idx.
  assign dig_a = work[{idx, 2'b00} +: DIGIT_W];
  assign dig_b = addend[{idx, 2'b00} +: DIGIT_W];

  bcd_digit_add u_digit_add (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry),
    .sum  (dig_sum),
    .cout (dig_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = ADD;
        ADD:     if (idx == 2'd3) state_nxt = COMMIT;
        COMMIT:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Committed score only changes in COMMIT (or clr), so the display never
  // sees a partially added value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      work   <= '0;
      addend <= '0;
      carry  <= 1'b0;
      score  <= '0;
      sat_r  <= 1'b0;
    end else if (clr) begin
      idx    <= '0;
      carry  <= 1'b0;
      score  <= '0;
      sat_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addend <= table_pts;
            work   <= score;
            carry  <= 1'b0;
            idx    <= '0;
          end
        end
        ADD: begin
          work[{idx, 2'b00} +: DIGIT_W] <= dig_sum;
          carry <= dig_cout;
          idx   <= idx + 2'd1;
        end
        COMMIT: begin
          if (carry) begin
            score <= {NDIGITS{4'd9}};
            sat_r <= 1'b1;
          end else begin
            score <= work;
          end
        end
        default: ;
      endcase
    end
  end

  assign {s4, s3, s2, s1} = score;
  assign sat              = sat_r;

endmodule
